time_counters: RTL and testbench
================================

TIME_COUNTERS -- requirements
Module: time_counters

Interface
REQ-001 The block SHALL have one parameter: CLKS_PER_SEC, default 25000000, i_Clock cycles per second (minimum 2).
REQ-002 The block SHALL have these ports, clock and reset first:
- i_Clock  in  1  single clock; all state changes on its rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Counters_Reset  in  1  clears seconds and prescaler.
- i_Counters_Enable_Increment  in  1  1 = manual-set mode; 0 = timekeeping mode.
- i_Counters_Enable_Count  in  3  field enables: bit0 seconds, bit1 minutes, bit2 hours.
- i_Increment  in  1  single-cycle pulse from the debounced set button.
- o_Seconds  out  8  BCD seconds, [7:4] tens, [3:0] ones, 00-59.
- o_Minutes  out  8  BCD minutes, 00-59.
- o_Hours  out  8  BCD hours, 00-23.
- o_Second_Tick  out  1  one-cycle pulse at each prescaler terminal count.
REQ-003 All outputs SHALL be driven directly from registers.

Function
REQ-004 The prescaler SHALL count 0 to CLKS_PER_SEC-1 and wrap to 0, with a width of clog2(CLKS_PER_SEC) bits.
REQ-005 The prescaler SHALL advance only when i_Counters_Enable_Increment=0 and i_Counters_Enable_Count[0]=1; otherwise it SHALL hold its value.
REQ-006 On the cycle the prescaler wraps, o_Second_Tick SHALL be 1 for exactly one cycle, registered and coincident with the seconds update.
REQ-007 Timekeeping mode, on each tick: seconds SHALL increment; on a 59->00 wrap, minutes SHALL increment if Count[1]=1; on a minutes 59->00 wrap, hours SHALL increment if Count[2]=1.
REQ-008 A disabled field SHALL hold its value and SHALL block any carry into higher fields.
REQ-009 23:59:59 plus one tick SHALL give 00:00:00 in the same cycle.
REQ-010 Manual-set mode: each i_Increment pulse SHALL increment every field whose Count bit is 1, by one, independently, with no carry between fields.
REQ-011 Manual-set wraps SHALL be: minutes 59->00 with hours unchanged; seconds 59->00 with minutes unchanged; hours 23->00.
REQ-012 In timekeeping mode, i_Increment SHALL be ignored.
REQ-013 BCD rules for seconds and minutes: the ones digit wraps 9->0 and increments tens; tens wraps 5->0 when ones wraps.
REQ-014 BCD rules for hours: ones 9->0 with tens+1; 23->00.
REQ-015 Digits SHALL never hold values outside their legal range.
REQ-016 i_Counters_Reset=1 SHALL clear seconds to 8'h00 and the prescaler to 0 on the next edge, SHALL hold o_Second_Tick at 0, and SHALL leave minutes and hours unchanged.
REQ-017 Priority per cycle SHALL be: i_Reset > i_Counters_Reset > manual increment > timekeeping tick.
REQ-018 Holding i_Counters_Reset for several cycles SHALL keep seconds at 00 for that whole period.
REQ-019 A change of i_Counters_Enable_Count or mode SHALL take effect on the next edge, with no lost or double increment.
REQ-020 Any partial prescaler count SHALL be retained across a mode change.

Reset
REQ-021 When i_Reset=1 at a rising edge, all of the following SHALL be cleared: o_Seconds=o_Minutes=o_Hours=8'h00, o_Second_Tick=0, prescaler=0.
REQ-022 i_Reset SHALL override every other input, including mid-count and during manual-set mode.
REQ-023 Counting SHALL resume from the first edge after i_Reset deasserts.

Verification
REQ-024 The bench SHALL cover these directed scenarios with CLKS_PER_SEC=4:
- Run: reset, then Increment_Enable=0, Count=111 for 4 cycles -> o_Second_Tick pulses once, o_Seconds=8'h01; after 40 cycles -> o_Seconds=8'h10.
- Rollover: set 23:59 via manual mode, run to seconds 59, one more tick -> 00:00:00 in a single cycle.
- Set minutes: Increment_Enable=1, Count=010, minutes 8'h58, 3 i_Increment pulses -> o_Minutes=8'h01, o_Hours and o_Seconds unchanged, no tick.
- Set hours: hours 8'h23, Count=100, one pulse -> 8'h00; hours 8'h09, one pulse -> 8'h10.
- Counters_Reset: at 12:34:37 with prescaler=2, pulse i_Counters_Reset -> 12:34:00, prescaler 0, next tick exactly 4 cycles later.
- Precedence: i_Reset and i_Counters_Reset asserted together, plus i_Increment in manual mode, at 05:06:07 -> 00:00:00, no tick; a field disabled in timekeeping mode holds its value and blocks carry.

Source files
------------

// File: rtl/time_counters.sv
// BCD hh:mm:ss timekeeper with a one-second prescaler and a manual-set mode.
// Each Count bit enables one field; disabled fields hold and block carries.
module time_counters #(
  parameter int CLKS_PER_SEC = 25000000
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Counters_Reset,
  input  logic       i_Counters_Enable_Increment,
  input  logic [2:0] i_Counters_Enable_Count,
  input  logic       i_Increment,
  output logic [7:0] o_Seconds,
  output logic [7:0] o_Minutes,
  output logic [7:0] o_Hours,
  output logic       o_Second_Tick
);

  localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TERM = PW'(CLKS_PER_SEC - 1);

  logic [PW-1:0] presc;
  logic          set_mode;
  logic          run_sec;
  logic          wrap_tick;

  assign set_mode  = i_Counters_Enable_Increment;
  assign run_sec   = !set_mode && i_Counters_Enable_Count[0];
  assign wrap_tick = run_sec && (presc == TERM);

  function automatic logic [7:0] inc60(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [7:0] inc24(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v == 8'h23) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      presc         <= '0;
      o_Seconds     <= 8'h00;
      o_Minutes     <= 8'h00;
      o_Hours       <= 8'h00;
      o_Second_Tick <= 1'b0;
    end else if (i_Counters_Reset) begin
      presc         <= '0;
      o_Seconds     <= 8'h00;
      o_Second_Tick <= 1'b0;
    end else if (set_mode) begin
      // Prescaler holds here so a partial second survives the mode change.
      o_Second_Tick <= 1'b0;
      if (i_Increment) begin
        if (i_Counters_Enable_Count[0]) o_Seconds <= inc60(o_Seconds);
        if (i_Counters_Enable_Count[1]) o_Minutes <= inc60(o_Minutes);
        if (i_Counters_Enable_Count[2]) o_Hours   <= inc24(o_Hours);
      end
    end else begin
      o_Second_Tick <= wrap_tick;
      if (wrap_tick) begin
        presc     <= '0;
        o_Seconds <= inc60(o_Seconds);
        if (o_Seconds == 8'h59 && i_Counters_Enable_Count[1]) begin
          o_Minutes <= inc60(o_Minutes);
          if (o_Minutes == 8'h59 && i_Counters_Enable_Count[2])
            o_Hours <= inc24(o_Hours);
        end
      end else if (run_sec) begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_time_counters.sv
// Scoreboard bench for time_counters: an integer reference model queues the
// expected hh:mm:ss/tick per cycle; each entry is compared after its edge.
module tb_time_counters;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       crst = 1'b0;
  logic       ie = 1'b0;
  logic [2:0] cnt = 3'b000;
  logic       inc = 1'b0;
  logic [7:0] sec, min, hr;
  logic       tick;

  int vectors = 0;
  int errs = 0;

  int ms = 0, mm = 0, mh = 0, mp = 0;
  bit mt = 1'b0;
  logic [24:0] sb[$];

  time_counters #(.CLKS_PER_SEC(N)) dut (
    .i_Clock(clk),
    .i_Reset(rst),
    .i_Counters_Reset(crst),
    .i_Counters_Enable_Increment(ie),
    .i_Counters_Enable_Count(cnt),
    .i_Increment(inc),
    .o_Seconds(sec),
    .o_Minutes(min),
    .o_Hours(hr),
    .o_Second_Tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic model(input bit r, input bit cr, input bit m,
                       input bit [2:0] c, input bit p);
    if (r) begin
      ms = 0; mm = 0; mh = 0; mp = 0; mt = 0;
    end else if (cr) begin
      ms = 0; mp = 0; mt = 0;
    end else if (m) begin
      mt = 0;
      if (p) begin
        if (c[0]) ms = (ms + 1) % 60;
        if (c[1]) mm = (mm + 1) % 60;
        if (c[2]) mh = (mh + 1) % 24;
      end
    end else begin
      mt = 0;
      if (c[0]) begin
        if (mp == N - 1) begin
          mp = 0;
          mt = 1;
          ms++;
          if (ms == 60) begin
            ms = 0;
            if (c[1]) begin
              mm++;
              if (mm == 60) begin
                mm = 0;
                if (c[2]) mh = (mh + 1) % 24;
              end
            end
          end
        end else begin
          mp++;
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit cr, input bit m,
                     input bit [2:0] c, input bit p);
    logic [24:0] e;
    rst = r; crst = cr; ie = m; cnt = c; inc = p;
    model(r, cr, m, c, p);
    sb.push_back({bcd(mh), bcd(mm), bcd(ms), mt});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("state", {7'd0, hr, min, sec, tick}, {7'd0, e});
  endtask

  task automatic run(input bit [2:0] c, input int n);
    repeat (n) cyc(0, 0, 0, c, 0);
  endtask

  task automatic pulses(input bit [2:0] c, input int n);
    repeat (n) begin
      cyc(0, 0, 1, c, 1);
      cyc(0, 0, 1, c, 0);
    end
  endtask

  initial begin
    cyc(1, 0, 0, 3'b000, 0);
    cyc(1, 0, 0, 3'b000, 0);
    chk("reset", {hr, min, sec, 7'd0, tick}, 32'd0);

    // run: one tick every 4 cycles, increments ignored in timekeeping
    run(3'b111, 3);
    chk("run_pre_tick", {31'd0, tick}, 32'd0);
    cyc(0, 0, 0, 3'b111, 1);
    chk("run_tick", {31'd0, tick}, 32'd1);
    chk("run_s01", {24'd0, sec}, 32'h01);
    run(3'b111, 36);
    chk("run_s10", {24'd0, sec}, 32'h10);

    // partial prescaler count survives a mode change
    run(3'b111, 2);
    pulses(3'b000, 2);
    run(3'b111, 1);
    chk("retain_no_tick", {31'd0, tick}, 32'd0);
    run(3'b111, 1);
    chk("retain_tick", {24'd0, sec, 7'd0, tick}, 32'h1101);

    // set minutes across 59->00, no carry, no tick
    pulses(3'b010, 58);
    chk("set_m58", {24'd0, min}, 32'h58);
    pulses(3'b010, 3);
    chk("set_m01", {hr, min, sec, 7'd0, tick}, 32'h0001_1100);

    // set hours: 23->00 and 09->10
    pulses(3'b100, 23);
    chk("set_h23", {24'd0, hr}, 32'h23);
    pulses(3'b100, 1);
    chk("set_h00", {24'd0, hr}, 32'h00);
    pulses(3'b100, 9);
    pulses(3'b100, 1);
    chk("set_h10", {24'd0, hr}, 32'h10);

    // manual seconds wrap leaves minutes alone
    pulses(3'b001, 49);
    chk("set_s00", {min, sec}, 32'h0100);

    // rollover: 23:59:59 + tick -> 00:00:00
    pulses(3'b100, 13);
    pulses(3'b010, 58);
    run(3'b111, 59 * N);
    chk("roll_pre", {hr, min, sec}, 32'h235959);
    run(3'b111, N);
    chk("roll", {hr, min, sec, 7'd0, tick}, 32'h0000_0001);

    // counters reset at 12:34:37 with prescaler at 2
    pulses(3'b100, 12);
    pulses(3'b010, 34);
    pulses(3'b001, 37);
    run(3'b111, 2);
    chk("cr_pre", {hr, min, sec}, 32'h123437);
    cyc(0, 1, 0, 3'b111, 0);
    cyc(0, 1, 0, 3'b111, 0);
    cyc(0, 1, 1, 3'b111, 1);
    chk("cr_hold", {hr, min, sec, 7'd0, tick}, 32'h1234_0000);
    run(3'b111, 3);
    chk("cr_no_tick", {31'd0, tick}, 32'd0);
    run(3'b111, 1);
    chk("cr_tick4", {24'd0, sec, 7'd0, tick}, 32'h0101);

    // precedence: reset beats everything at 05:06:07
    cyc(1, 0, 0, 3'b000, 0);
    pulses(3'b100, 5);
    pulses(3'b010, 6);
    pulses(3'b001, 7);
    chk("prec_pre", {hr, min, sec}, 32'h050607);
    cyc(1, 1, 1, 3'b111, 1);
    chk("prec", {hr, min, sec, 7'd0, tick}, 32'd0);

    // minutes disabled: holds 59 and blocks carry into hours
    pulses(3'b010, 59);
    pulses(3'b001, 59);
    run(3'b101, N);
    chk("dis_block", {hr, min, sec, 7'd0, tick}, 32'h0059_0001);
    // seconds disabled: prescaler and seconds frozen
    run(3'b110, 2 * N);
    chk("dis_sec", {hr, min, sec, 7'd0, tick}, 32'h0059_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
